pointing_device_uart_tx: RTL and testbench

Serializer stage directly downstream of the pointing-device byte generator. It accepts bytes on a write/data strobe, buffers them in a small FIFO and shifts each one out as an 8N1 asynchronous serial frame at 1200 baud, or 1500 baud when overclocked. Its output drives the receive line of the system controller's pointer UART. The upstream RTS also drives this block's flush input, so a flush discards stale bytes.

---
 rtl/pointing_device_uart_tx.sv | 151 +++++++++++++++
 tb/tb_pointing_device_uart_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pointing_device_uart_tx.sv
// Byte FIFO feeding an 8N1 serializer for the pointer UART receive line.
// The divider is latched once per frame; flush discards queued bytes and aborts the frame.
module pointing_device_uart_tx #(
    parameter int unsigned DivNormal    = 25000,
    parameter int unsigned DivOverclock = 20000,
    parameter int unsigned FifoDepth    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         overclock_i,
    input  logic                         flush_i,
    input  logic                         in_write_i,
    input  logic [7:0]                   in_data_i,
    output logic                         txd_o,
    output logic                         busy_o,
    output logic [$clog2(FifoDepth):0]   fifo_level_o,
    output logic                         overflow_o
);

    localparam int unsigned AddrW = $clog2(FifoDepth);
    localparam int unsigned PtrW  = AddrW + 1;

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q;
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [7:0]      mem_q [FifoDepth];
    logic [7:0]      shift_q;
    logic [2:0]      bit_q;
    logic [14:0]     cnt_q, div_q;
    logic            txd_q, busy_q, overflow_q;

    logic [PtrW-1:0] level, level_d;
    logic            empty, full, last, pop, push, idle_next;
    logic [7:0]      head;
    logic [14:0]     div_sel;

    always_comb begin
        level     = wr_ptr_q - rd_ptr_q;
        empty     = (level == '0);
        full      = (level == PtrW'(FifoDepth));
        last      = (cnt_q == div_q - 15'd1);
        pop       = !flush_i && !empty &&
                    ((state_q == StIdle) || ((state_q == StStop) && last));
        push      = in_write_i && !flush_i && (!full || pop);
        level_d   = flush_i ? '0 : level + PtrW'(push) - PtrW'(pop);
        idle_next = flush_i || ((state_q == StIdle) && empty) ||
                    ((state_q == StStop) && last && empty);
        head      = mem_q[rd_ptr_q[AddrW-1:0]];
        div_sel   = overclock_i ? 15'(DivOverclock) : 15'(DivNormal);
    end

    // Storage needs no reset: occupancy is tracked entirely by the pointers.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= in_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            shift_q    <= '0;
            bit_q      <= '0;
            cnt_q      <= '0;
            div_q      <= 15'(DivNormal);
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= in_write_i && !flush_i && full && !pop;
            busy_q     <= !idle_next || (level_d != '0);
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                state_q  <= StIdle;
                txd_q    <= 1'b1;
                cnt_q    <= '0;
                bit_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + PtrW'(1);
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + PtrW'(1);
                    shift_q  <= head;
                    div_q    <= div_sel;
                end
                unique case (state_q)
                    StIdle: begin
                        cnt_q <= '0;
                        if (pop) begin
                            state_q <= StStart;
                            txd_q   <= 1'b0;
                        end else begin
                            txd_q   <= 1'b1;
                        end
                    end
                    StStart: begin
                        if (last) begin
                            state_q <= StData;
                            bit_q   <= '0;
                            cnt_q   <= '0;
                            txd_q   <= shift_q[0];
                        end else begin
                            cnt_q <= cnt_q + 15'd1;
                        end
                    end
                    StData: begin
                        if (last) begin
                            cnt_q <= '0;
                            if (bit_q == 3'd7) begin
                                state_q <= StStop;
                                txd_q   <= 1'b1;
                            end else begin
                                bit_q <= bit_q + 3'd1;
                                txd_q <= shift_q[bit_q + 3'd1];
                            end
                        end else begin
                            cnt_q <= cnt_q + 15'd1;
                        end
                    end
                    StStop: begin
                        if (last) begin
                            cnt_q <= '0;
                            // Back-to-back: a queued byte starts its frame with no idle gap.
                            if (pop) begin
                                state_q <= StStart;
                                txd_q   <= 1'b0;
                            end else begin
                                state_q <= StIdle;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q + 15'd1;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign txd_o        = txd_q;
    assign busy_o       = busy_q;
    assign fifo_level_o = level;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_pointing_device_uart_tx.sv
// Directed bench for pointing_device_uart_tx using shortened bit periods.
module tb_pointing_device_uart_tx;

    localparam int unsigned DivN  = 10;
    localparam int unsigned DivO  = 8;
    localparam int unsigned Depth = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       overclock, flush, in_write;
    logic [7:0] in_data;
    logic       txd, busy, overflow;
    logic [2:0] fifo_level;

    int n_vec  = 0;
    int n_miss = 0;

    pointing_device_uart_tx #(
        .DivNormal   (DivN),
        .DivOverclock(DivO),
        .FifoDepth   (Depth)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .overclock_i (overclock),
        .flush_i     (flush),
        .in_write_i  (in_write),
        .in_data_i   (in_data),
        .txd_o       (txd),
        .busy_o      (busy),
        .fifo_level_o(fifo_level),
        .overflow_o  (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [7:0] d);
        in_write = 1'b1;
        in_data  = d;
        tick();
        in_write = 1'b0;
    endtask

    // Entered just after the edge that starts the start bit; returns after the stop bit ends.
    task automatic expect_frame(input logic [7:0] d, input int unsigned div);
        logic exp;
        for (int b = 0; b < 10; b++) begin
            exp = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b-1];
            for (int c = 0; c < int'(div); c++) begin
                if (c == 0 || c == int'(div) - 1) begin
                    check($sformatf("frame_%02h_bit%0d_c%0d", d, b, c), 32'(txd), 32'(exp));
                end
                tick();
            end
        end
    endtask

    // Line must stay idle: count low cycles over a window.
    task automatic expect_quiet(input string tag, input int cycles);
        int lows = 0;
        for (int i = 0; i < cycles; i++) begin
            if (txd !== 1'b1) lows++;
            tick();
        end
        check(tag, 32'(lows), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; overclock = 1'b0; flush = 1'b0; in_write = 1'b0; in_data = 8'h00;
        #23;
        check("reset_txd", 32'(txd), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_level", 32'(fifo_level), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        #4 rst_n = 1'b1;
        tick();

        // Single byte: one-cycle pop latency, then a full 10*DIV frame.
        write(8'hCA);
        check("t1_txd_after_write", 32'(txd), 32'd1);
        check("t1_busy_after_write", 32'(busy), 32'd1);
        check("t1_level_after_write", 32'(fifo_level), 32'd1);
        tick();
        check("t1_level_after_pop", 32'(fifo_level), 32'd0);
        expect_frame(8'hCA, DivN);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_txd_end", 32'(txd), 32'd1);
        expect_quiet("t1_quiet", 3 * DivN);

        // Three bytes two cycles apart: contiguous frames.
        write(8'hC0);
        tick();
        fork
            expect_frame(8'hC0, DivN);
            begin
                write(8'h85);
                tick();
                write(8'h9E);
            end
        join
        expect_frame(8'h85, DivN);
        expect_frame(8'h9E, DivN);
        check("t2_busy_end", 32'(busy), 32'd0);
        expect_quiet("t2_quiet", 2 * DivN);

        // Six consecutive writes: fifth fills the FIFO, sixth is dropped.
        write(8'h11);
        fork
            begin
                tick();
                check("t3_level_e2", 32'(fifo_level), 32'd1);
                expect_frame(8'h11, DivN);
                expect_frame(8'h22, DivN);
                expect_frame(8'h33, DivN);
                expect_frame(8'h44, DivN);
                expect_frame(8'h55, DivN);
                check("t3_busy_end", 32'(busy), 32'd0);
                expect_quiet("t3_no_sixth_frame", 12 * DivN);
            end
            begin
                write(8'h22);
                write(8'h33);
                write(8'h44);
                write(8'h55);
                check("t3_no_ovf_before_full", 32'(overflow), 32'd0);
                write(8'h66);
                check("t3_ovf_pulse", 32'(overflow), 32'd1);
                check("t3_level_full", 32'(fifo_level), 32'(Depth));
                tick();
                check("t3_ovf_single", 32'(overflow), 32'd0);
            end
        join

        // Flush mid-DATA with two bytes queued, writes ignored while flushing.
        write(8'hA1);
        write(8'hB2);
        write(8'hC3);
        check("t4_level_queued", 32'(fifo_level), 32'd2);
        for (int i = 0; i < 3 * int'(DivN); i++) tick();
        flush = 1'b1;
        in_write = 1'b1;
        in_data = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("t4_flush_txd_%0d", i), 32'(txd), 32'd1);
            check($sformatf("t4_flush_level_%0d", i), 32'(fifo_level), 32'd0);
            check($sformatf("t4_flush_busy_%0d", i), 32'(busy), 32'd0);
            check($sformatf("t4_flush_ovf_%0d", i), 32'(overflow), 32'd0);
        end
        flush = 1'b0;
        in_write = 1'b0;
        expect_quiet("t4_no_frames_after_flush", 12 * DivN);
        check("t4_busy_after_flush", 32'(busy), 32'd0);
        write(8'h5A);
        tick();
        expect_frame(8'h5A, DivN);
        check("t4_busy_end", 32'(busy), 32'd0);

        // Overclock latched per frame; a mid-frame change affects only the next one.
        overclock = 1'b1;
        write(8'h55);
        tick();
        fork
            expect_frame(8'h55, DivO);
            begin
                for (int i = 0; i < 20; i++) tick();
                overclock = 1'b0;
                write(8'h0F);
            end
        join
        expect_frame(8'h0F, DivN);
        check("t5_busy_end", 32'(busy), 32'd0);

        // Asynchronous reset mid-frame.
        write(8'h3C);
        tick();
        for (int i = 0; i < 25; i++) tick();
        check("t6_in_frame_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_txd", 32'(txd), 32'd1);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_level", 32'(fifo_level), 32'd0);
        tick();
        tick();
        tick();
        #3 rst_n = 1'b1;
        tick();
        expect_quiet("t6_no_residual", 12 * DivN);
        check("t6_busy_after", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
